// File: rtl/z16_instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : z16_instr_fetch
// Description : Z16 instruction-fetch front end. Owns the PC, reads the
//               instruction memory combinationally, and queues
//               {pc, instr} pairs in a small FIFO that feeds decode over
//               a valid/ready handshake. Supports branch redirect and
//               fetch enable.
// Revision    : 1.0 - initial release
// ============================================================================
module z16_instr_fetch #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int          DEPTH    = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    output logic [15:0] o_imem_addr,
    input  logic [15:0] i_imem_instr,
    input  logic        i_fetch_en,
    input  logic        i_redirect,
    input  logic [15:0] i_redirect_pc,
    output logic        o_instr_valid,
    output logic [15:0] o_instr,
    output logic [15:0] o_instr_pc,
    input  logic        i_instr_ready
);

    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CNT_W = $clog2(DEPTH + 1);

    logic [15:0]        pc_q,     pc_d;
    logic [c_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [c_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [c_CNT_W-1:0] count_q,  count_d;
    logic [31:0]        fifo_mem_q [DEPTH];

    logic w_push;
    logic w_pop;
    logic w_unused_redirect_bit0;

    // Bit 0 of the redirect target is forced to zero, so it is never read.
    assign w_unused_redirect_bit0 = i_redirect_pc[0];

    // Head outputs depend only on FIFO state; zeroed when empty.
    assign o_instr_valid = (count_q != '0);
    assign o_instr       = o_instr_valid ? fifo_mem_q[rd_ptr_q][15:0]  : 16'h0000;
    assign o_instr_pc    = o_instr_valid ? fifo_mem_q[rd_ptr_q][31:16] : 16'h0000;
    assign o_imem_addr   = pc_q;

    // Handshake qualifiers; a full FIFO never pushes, even on a same-cycle pop.
    assign w_pop  = o_instr_valid & i_instr_ready;
    assign w_push = i_fetch_en & ~i_redirect & (count_q < c_CNT_W'(DEPTH));

    // Next-state for PC, pointers and occupancy; redirect flushes everything.
    always_comb begin
        pc_d     = pc_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (i_redirect) begin
            pc_d     = {i_redirect_pc[15:1], 1'b0};
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (w_push) begin
                pc_d     = pc_q + 16'd2;
                wr_ptr_d = wr_ptr_q + c_PTR_W'(1);
            end
            if (w_pop) begin
                rd_ptr_d = rd_ptr_q + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   count_d = count_q + c_CNT_W'(1);
                2'b01:   count_d = count_q - c_CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pc_q     <= RESET_PC;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            pc_q     <= pc_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // FIFO storage; contents are don't-care while the slot is not occupied.
    always_ff @(posedge i_clk) begin
        if (!i_rst && w_push) begin
            fifo_mem_q[wr_ptr_q] <= {pc_q, i_imem_instr};
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_z16_instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_z16_instr_fetch
// Description : Self-checking bench for z16_instr_fetch: a queue-based
//               reference model compared every cycle, directed scenarios
//               with literal expectations, then randomized traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_z16_instr_fetch;

    localparam logic [15:0] c_RESET_PC = 16'h0000;
    localparam int          c_DEPTH    = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] imem_addr;
    logic [15:0] imem_instr;
    logic        fetch_en;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        instr_valid;
    logic [15:0] instr;
    logic [15:0] instr_pc;
    logic        instr_ready;

    int tests  = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Instruction memory image: three fixed words, everything else a
    // byte-swapped/scrambled copy of the address.
    function automatic logic [15:0] mem_at(input logic [15:0] a);
        case (a)
            16'h0000: return 16'h1111;
            16'h0002: return 16'h2222;
            16'h0004: return 16'h3333;
            default:  return {a[7:0], a[15:8]} ^ 16'h5A3C;
        endcase
    endfunction

    assign imem_instr = mem_at(imem_addr);

    z16_instr_fetch #(
        .RESET_PC (c_RESET_PC),
        .DEPTH    (c_DEPTH)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .o_imem_addr   (imem_addr),
        .i_imem_instr  (imem_instr),
        .i_fetch_en    (fetch_en),
        .i_redirect    (redirect),
        .i_redirect_pc (redirect_pc),
        .o_instr_valid (instr_valid),
        .o_instr       (instr),
        .o_instr_pc    (instr_pc),
        .i_instr_ready (instr_ready)
    );

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: PC plus a queue of {pc, instr} entries.
    logic [15:0] m_pc;
    logic [31:0] mq[$];
    bit          model_ok = 0;

    always @(posedge clk) begin
        bit do_pop, do_push;
        if (rst) begin
            m_pc = c_RESET_PC;
            mq.delete();
            model_ok = 1;
        end else begin
            do_pop  = (mq.size() != 0) && instr_ready;
            do_push = fetch_en && !redirect && (mq.size() < c_DEPTH);
            if (redirect) begin
                mq.delete();
                m_pc = {redirect_pc[15:1], 1'b0};
            end else begin
                if (do_pop)  void'(mq.pop_front());
                if (do_push) begin
                    mq.push_back({m_pc, mem_at(m_pc)});
                    m_pc = m_pc + 16'd2;
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (model_ok) begin
            check("addr",  imem_addr, m_pc);
            check("valid", {15'd0, instr_valid}, {15'd0, mq.size() != 0});
            check("instr", instr,    (mq.size() != 0) ? mq[0][15:0]  : 16'h0000);
            check("ipc",   instr_pc, (mq.size() != 0) ? mq[0][31:16] : 16'h0000);
        end
    end

    task automatic cyc(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic head(input string name, input logic v, input logic [15:0] p,
                        input logic [15:0] i);
        check({name, "_v"},   {15'd0, instr_valid}, {15'd0, v});
        check({name, "_pc"},  instr_pc, p);
        check({name, "_ins"}, instr,    i);
    endtask

    initial begin
        rst = 1; fetch_en = 1; redirect = 0; redirect_pc = 16'h0; instr_ready = 1;
        cyc(2);
        // Reset state
        check("rst_addr", imem_addr, c_RESET_PC);
        head("rst", 1'b0, 16'h0000, 16'h0000);

        // Streaming from reset
        rst = 0;
        cyc(1); head("s0", 1'b1, 16'h0000, 16'h1111); check("s0_addr", imem_addr, 16'h0002);
        cyc(1); head("s1", 1'b1, 16'h0002, 16'h2222); check("s1_addr", imem_addr, 16'h0004);
        cyc(1); head("s2", 1'b1, 16'h0004, 16'h3333); check("s2_addr", imem_addr, 16'h0006);

        // Backpressure: ready low for 5 cycles
        rst = 1; cyc(1); rst = 0; instr_ready = 0;
        cyc(1); head("bp1", 1'b1, 16'h0000, 16'h1111);
        cyc(4); head("bp5", 1'b1, 16'h0000, 16'h1111); check("bp5_addr", imem_addr, 16'h0004);
        instr_ready = 1;
        cyc(1); head("bpd0", 1'b1, 16'h0002, 16'h2222); check("bpd0_addr", imem_addr, 16'h0004);
        cyc(1); head("bpd1", 1'b1, 16'h0004, 16'h3333); check("bpd1_addr", imem_addr, 16'h0006);

        // Redirect with two entries queued and ready high
        instr_ready = 0; cyc(2);
        redirect = 1; redirect_pc = 16'h0041; instr_ready = 1;
        cyc(1); redirect = 0;
        head("rd0", 1'b0, 16'h0000, 16'h0000); check("rd0_addr", imem_addr, 16'h0040);
        cyc(1); head("rd1", 1'b1, 16'h0040, mem_at(16'h0040));

        // Redirect near the top of the address space: PC wrap
        redirect = 1; redirect_pc = 16'hFFFC;
        cyc(1); redirect = 0; check("wr_addr", imem_addr, 16'hFFFC);
        cyc(1); check("wr0", instr_pc, 16'hFFFC);
        cyc(1); check("wr1", instr_pc, 16'hFFFE);
        cyc(1); check("wr2", instr_pc, 16'h0000);
        cyc(1); check("wr3", instr_pc, 16'h0002);

        // Fetch disable with two entries queued
        redirect = 1; redirect_pc = 16'h0100; instr_ready = 0;
        cyc(1); redirect = 0;
        cyc(2); fetch_en = 0; instr_ready = 1;
        cyc(1); head("fe0", 1'b1, 16'h0102, mem_at(16'h0102));
        cyc(1); head("fe1", 1'b0, 16'h0000, 16'h0000); check("fe1_addr", imem_addr, 16'h0104);
        cyc(2); check("fe2_addr", imem_addr, 16'h0104);
        fetch_en = 1;
        cyc(1); head("fe3", 1'b1, 16'h0104, mem_at(16'h0104));

        // Reset overriding full FIFO plus simultaneous redirect
        instr_ready = 0; cyc(2);
        rst = 1; redirect = 1; redirect_pc = 16'h0200;
        cyc(1); rst = 0; redirect = 0;
        check("rr_addr", imem_addr, c_RESET_PC);
        head("rr", 1'b0, 16'h0000, 16'h0000);

        // Randomized traffic checked by the per-cycle model comparison
        for (int i = 0; i < 3000; i++) begin
            fetch_en    = ($urandom_range(0, 99) < 80);
            instr_ready = ($urandom_range(0, 99) < 60);
            redirect    = ($urandom_range(0, 99) < 5);
            redirect_pc = 16'($urandom);
            rst         = ($urandom_range(0, 199) == 0);
            cyc(1);
        end
        rst = 0; redirect = 0;
        cyc(2);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
`default_nettype wire
